// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one single-port SRAM between instruction fetch and load/store.
// Each access is an issue cycle followed by a response cycle; ties alternate between the masters.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] conflict_cnt
);

    // Handshake: a master raises *_req with stable payload and keeps it until its *_ready
    // pulse; the pulse marks the cycle in which *_rdata is valid.
    typedef enum logic [1:0] {IDLE, INST_WAIT, DATA_WAIT} state_t;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;   // 1: data master won the most recent grant
    logic [31:0] inst_hold_q, inst_hold_d;
    logic [31:0] data_hold_q, data_hold_d;
    logic [15:0] cnt_q, cnt_d;
    logic        grant_inst;
    logic        grant_data;

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        inst_hold_d  = inst_hold_q;
        data_hold_d  = data_hold_q;
        cnt_d        = cnt_q;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        inst_ready   = 1'b0;
        data_ready   = 1'b0;
        inst_rdata   = inst_hold_q;
        data_rdata   = data_hold_q;
        mem_en       = 1'b0;
        mem_wen      = 4'b0000;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        conflict_cnt = cnt_q;

        // Both masters high is a conflict in every state: a tie in IDLE, a stall otherwise.
        if (inst_req && data_req && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (inst_req && (!data_req || last_data_q)) begin
                    grant_inst = 1'b1;
                end else if (data_req) begin
                    grant_data = 1'b1;
                end
                if (grant_inst) begin
                    mem_en      = 1'b1;
                    mem_addr    = inst_addr;
                    last_data_d = 1'b0;
                    state_d     = INST_WAIT;
                end else if (grant_data) begin
                    mem_en      = 1'b1;
                    mem_wen     = data_wen;
                    mem_addr    = data_addr;
                    mem_wdata   = data_wdata;
                    last_data_d = 1'b1;
                    state_d     = DATA_WAIT;
                end
            end
            INST_WAIT: begin
                inst_ready  = 1'b1;
                inst_rdata  = mem_rdata;
                inst_hold_d = mem_rdata;
                state_d     = IDLE;
            end
            DATA_WAIT: begin
                data_ready  = 1'b1;
                data_rdata  = mem_rdata;
                data_hold_d = mem_rdata;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset masks every output in the same cycle, aborting any in-flight response.
        if (rst) begin
            inst_ready   = 1'b0;
            data_ready   = 1'b0;
            inst_rdata   = 32'h0;
            data_rdata   = 32'h0;
            mem_en       = 1'b0;
            mem_wen      = 4'b0000;
            mem_addr     = 32'h0;
            mem_wdata    = 32'h0;
            conflict_cnt = 16'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            inst_hold_q <= 32'h0;
            data_hold_q <= 32'h0;
            cnt_q       <= 16'h0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            inst_hold_q <= inst_hold_d;
            data_hold_q <= data_hold_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, round-robin sequence, random traffic against a
// reference model, and a long saturation run of the conflict counter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_ready   (inst_ready),
        .data_req     (data_req),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_ready   (data_ready),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: which master's response is due this cycle (0 none, 1 inst, 2 data),
    // who won the last grant, the two captured read values and the conflict total.
    int          m_resp = 0;
    bit          m_last_data = 1'b0;
    logic [31:0] m_ihold = 32'h0;
    logic [31:0] m_dhold = 32'h0;
    int          m_cnt = 0;

    // Values seen in the most recent step (model expectations and DUT observations).
    bit          g_iready;
    bit          g_dready;
    int          d_grant;
    logic        d_iready;
    logic        d_dready;
    logic [15:0] d_cnt;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwen;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] mrdata;
        logic        e_iready;
        logic [31:0] e_irdata;
        logic        e_dready;
        logic [31:0] e_drdata;
        logic        e_men;
        logic [3:0]  e_mwen;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [150:0] pack_dut();
        return {conflict_cnt, inst_ready, inst_rdata, data_ready, data_rdata,
                mem_en, mem_wen, mem_addr, mem_wdata};
    endfunction

    task automatic compare(input string name, input logic [150:0] act, input logic [150:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check outputs, advance model, pass the edge.
    task automatic step(input string name, input bit use_tbl, input logic [150:0] tbl_exp);
        bit          both;
        int          winner;
        logic        e_iready, e_dready, e_men;
        logic [31:0] e_irdata, e_drdata, e_maddr, e_mwdata;
        logic [3:0]  e_mwen;
        logic [15:0] e_cnt;
        #1;
        both = inst_req && data_req;
        winner = 0;
        e_iready = 0; e_dready = 0; e_men = 0; e_mwen = 0;
        e_irdata = 0; e_drdata = 0; e_maddr = 0; e_mwdata = 0; e_cnt = 0;
        if (!rst) begin
            e_cnt    = 16'(m_cnt);
            e_irdata = m_ihold;
            e_drdata = m_dhold;
            if (m_resp == 1) begin
                e_iready = 1; e_irdata = mem_rdata;
            end else if (m_resp == 2) begin
                e_dready = 1; e_drdata = mem_rdata;
            end else begin
                if (both) winner = m_last_data ? 1 : 2;
                else if (inst_req) winner = 1;
                else if (data_req) winner = 2;
                if (winner == 1) begin
                    e_men = 1; e_maddr = inst_addr;
                end else if (winner == 2) begin
                    e_men = 1; e_mwen = data_wen; e_maddr = data_addr; e_mwdata = data_wdata;
                end
            end
        end
        compare({name, "/model"}, pack_dut(),
                {e_cnt, e_iready, e_irdata, e_dready, e_drdata, e_men, e_mwen, e_maddr, e_mwdata});
        if (use_tbl) compare({name, "/table"}, pack_dut(), tbl_exp);
        g_iready = e_iready;
        g_dready = e_dready;
        d_grant  = !mem_en ? 0 : (mem_addr == inst_addr && mem_wen == 4'h0 && inst_req) ? 1 : 2;
        d_iready = inst_ready;
        d_dready = data_ready;
        d_cnt    = conflict_cnt;
        if (rst) begin
            m_resp = 0; m_last_data = 0; m_ihold = 0; m_dhold = 0; m_cnt = 0;
        end else begin
            if (m_resp == 1) m_ihold = mem_rdata;
            if (m_resp == 2) m_dhold = mem_rdata;
            if (both && m_cnt < 65535) m_cnt++;
            if (m_resp != 0) m_resp = 0;
            else begin
                m_resp = winner;
                if (winner != 0) m_last_data = (winner == 2);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input int i);
        rst        = tbl[i].rst;
        inst_req   = tbl[i].ireq;
        inst_addr  = tbl[i].iaddr;
        data_req   = tbl[i].dreq;
        data_wen   = tbl[i].dwen;
        data_addr  = tbl[i].daddr;
        data_wdata = tbl[i].dwdata;
        mem_rdata  = tbl[i].mrdata;
        step($sformatf("row%0d", i), 1'b1,
             {tbl[i].e_cnt, tbl[i].e_iready, tbl[i].e_irdata, tbl[i].e_dready, tbl[i].e_drdata,
              tbl[i].e_men, tbl[i].e_mwen, tbl[i].e_maddr, tbl[i].e_mwdata});
    endtask

    initial begin
        rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wen = 0;
        data_addr = 0; data_wdata = 0; mem_rdata = 0;

        //         rst ireq iaddr         dreq dwen  daddr         dwdata        mrdata
        //         irdy irdata            drdy drdata         men mwen  maddr          mwdata        cnt
        tbl[0]  = '{1, 0, 32'h0,          0, 4'h0, 32'h0,         32'h0,        32'h0,
                    0, 32'h0,             0, 32'h0,           0, 4'h0, 32'h0,         32'h0,        16'd0};
        tbl[1]  = '{0, 1, 32'hBFC00000,   0, 4'h0, 32'h0,         32'h0,        32'h0,
                    0, 32'h0,             0, 32'h0,           1, 4'h0, 32'hBFC00000,  32'h0,        16'd0};
        tbl[2]  = '{0, 1, 32'hBFC00000,   0, 4'h0, 32'h0,         32'h0,        32'h24080001,
                    1, 32'h24080001,      0, 32'h0,           0, 4'h0, 32'h0,         32'h0,        16'd0};
        tbl[3]  = '{0, 0, 32'h0,          0, 4'h0, 32'h0,         32'h0,        32'h55,
                    0, 32'h24080001,      0, 32'h0,           0, 4'h0, 32'h0,         32'h0,        16'd0};
        tbl[4]  = '{0, 0, 32'h0,          1, 4'hF, 32'h80000020,  32'hDEADBEEF, 32'h0,
                    0, 32'h24080001,      0, 32'h0,           1, 4'hF, 32'h80000020,  32'hDEADBEEF, 16'd0};
        tbl[5]  = '{0, 0, 32'h0,          1, 4'hF, 32'h80000020,  32'hDEADBEEF, 32'h11111111,
                    0, 32'h24080001,      1, 32'h11111111,    0, 4'h0, 32'h0,         32'h0,        16'd0};
        tbl[6]  = '{0, 0, 32'h0,          0, 4'h0, 32'h0,         32'h0,        32'h0,
                    0, 32'h24080001,      0, 32'h11111111,    0, 4'h0, 32'h0,         32'h0,        16'd0};
        tbl[7]  = '{1, 0, 32'h0,          0, 4'h0, 32'h0,         32'h0,        32'h77,
                    0, 32'h0,             0, 32'h0,           0, 4'h0, 32'h0,         32'h0,        16'd0};
        tbl[8]  = '{0, 1, 32'hBFC00004,   1, 4'h0, 32'h80000010,  32'h0,        32'h0,
                    0, 32'h0,             0, 32'h0,           1, 4'h0, 32'h80000010,  32'h0,        16'd0};
        tbl[9]  = '{0, 1, 32'hBFC00004,   1, 4'h0, 32'h80000010,  32'h0,        32'hCAFEF00D,
                    0, 32'h0,             1, 32'hCAFEF00D,    0, 4'h0, 32'h0,         32'h0,        16'd1};
        tbl[10] = '{0, 1, 32'hBFC00004,   0, 4'h0, 32'h0,         32'h0,        32'h0,
                    0, 32'h0,             0, 32'hCAFEF00D,    1, 4'h0, 32'hBFC00004,  32'h0,        16'd2};
        tbl[11] = '{0, 1, 32'hBFC00004,   0, 4'h0, 32'h0,         32'h0,        32'h12345678,
                    1, 32'h12345678,      0, 32'hCAFEF00D,    0, 4'h0, 32'h0,         32'h0,        16'd2};
        tbl[12] = '{0, 0, 32'h0,          0, 4'h0, 32'h0,         32'h0,        32'h0,
                    0, 32'h12345678,      0, 32'hCAFEF00D,    0, 4'h0, 32'h0,         32'h0,        16'd2};
        tbl[13] = '{0, 1, 32'h100,        0, 4'h0, 32'h0,         32'h0,        32'h0,
                    0, 32'h12345678,      0, 32'hCAFEF00D,    1, 4'h0, 32'h100,       32'h0,        16'd2};
        tbl[14] = '{1, 1, 32'h100,        0, 4'h0, 32'h0,         32'h0,        32'hAAAA5555,
                    0, 32'h0,             0, 32'h0,           0, 4'h0, 32'h0,         32'h0,        16'd0};
        tbl[15] = '{0, 1, 32'h100,        0, 4'h0, 32'h0,         32'h0,        32'h0,
                    0, 32'h0,             0, 32'h0,           1, 4'h0, 32'h100,       32'h0,        16'd0};
        tbl[16] = '{0, 1, 32'h100,        0, 4'h0, 32'h0,         32'h0,        32'h0BADCAFE,
                    1, 32'h0BADCAFE,      0, 32'h0,           0, 4'h0, 32'h0,         32'h0,        16'd0};
        tbl[17] = '{0, 0, 32'h0,          0, 4'h0, 32'h0,         32'h0,        32'h0,
                    0, 32'h0BADCAFE,      0, 32'h0,           0, 4'h0, 32'h0,         32'h0,        16'd0};

        for (int i = 0; i < 18; i++) apply_row(i);

        // Both masters held: grants go data, -, inst, -, data ... and each ready every 4 cycles.
        rst = 0; inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_wen = 4'h0; data_addr = 32'h2000; data_wdata = 32'h0;
        for (int k = 0; k < 20; k++) begin
            mem_rdata = $urandom;
            step("rr", 1'b0, 151'(0));
            compare("rr_grant", 151'(d_grant), 151'((k % 4 == 0) ? 2 : (k % 4 == 2) ? 1 : 0));
            compare("rr_data_ready", 151'(d_dready), 151'(k % 4 == 1));
            compare("rr_inst_ready", 151'(d_iready), 151'(k % 4 == 3));
        end
        inst_req = 0; data_req = 0;
        step("rr_end", 1'b0, 151'(0));

        // Random legal traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if (g_iready) inst_req = 0;
            if (g_dready) data_req = 0;
            if (!inst_req && $urandom_range(0, 2) != 0) begin
                inst_req = 1; inst_addr = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) != 0) begin
                data_req   = 1;
                data_addr  = $urandom;
                data_wdata = $urandom;
                data_wen   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            rst = ($urandom_range(0, 99) == 0);
            mem_rdata = $urandom;
            step("rand", 1'b0, 151'(0));
        end

        // Drive the conflict counter to saturation.
        rst = 1; mem_rdata = 0;
        step("sat_rst", 1'b0, 151'(0));
        rst = 0; inst_req = 1; inst_addr = 32'h40; data_req = 1; data_wen = 4'h3;
        data_addr = 32'h80; data_wdata = 32'h5A5A5A5A;
        for (int n = 0; n < 65534; n++) begin
            mem_rdata = $urandom;
            step("sat", 1'b0, 151'(0));
        end
        step("sat_fffe", 1'b0, 151'(0));
        compare("cnt_fffe", 151'(d_cnt), 151'(16'hFFFE));
        step("sat", 1'b0, 151'(0));
        step("sat", 1'b0, 151'(0));
        step("sat_ffff", 1'b0, 151'(0));
        compare("cnt_ffff", 151'(d_cnt), 151'(16'hFFFF));
        step("sat_hold", 1'b0, 151'(0));
        compare("cnt_hold", 151'(d_cnt), 151'(16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
